// File: rtl/game_seq_ctrl.sv
// Parametrised game-flow sequencer: phases, signed stability
// penalties with saturation, optional phase retry and debug jumps.
module game_seq_ctrl #(
  parameter int NUM_PHASES    = 4,
  parameter int STATE_W       = 4,
  parameter int STAB_INIT     = 5,
  parameter int STAB_MAX      = 9,
  parameter int FAIL_PENALTY  = 1,
  parameter int EVENT_PENALTY = 2,
  parameter int RETRY_MODE    = 0,
  parameter int MAX_RETRY     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_pulse,
  input  logic [NUM_PHASES-1:0] phase_clear,
  input  logic                  puzzle_fail,
  input  logic                  event_fail,
  input  logic                  recover,
  input  logic                  time_out,
  input  logic                  debug_force,
  input  logic [STATE_W-1:0]    debug_state,
  output logic [STATE_W-1:0]    current_state,
  output logic [NUM_PHASES-1:0] phase_onehot,
  output logic [3:0]            stability,
  output logic [3:0]            retries_left,
  output logic                  game_enable,
  output logic                  timer_reset,
  output logic                  phase_restart,
  output logic                  game_clear,
  output logic                  game_over
);

  localparam logic [STATE_W-1:0] S_IDLE  = '0;
  localparam logic [STATE_W-1:0] S_FIRST = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_LAST  = STATE_W'(NUM_PHASES);
  localparam logic [STATE_W-1:0] S_CLEAR = STATE_W'(NUM_PHASES + 1);
  localparam logic [STATE_W-1:0] S_OVER  = STATE_W'(NUM_PHASES + 2);

  localparam logic [3:0] INIT4  = 4'(STAB_INIT);
  localparam logic [3:0] RETRY4 = 4'(MAX_RETRY);
  localparam logic [5:0] MAX6   = 6'(STAB_MAX);
  localparam logic [5:0] FP6    = 6'(FAIL_PENALTY);
  localparam logic [5:0] EP6    = 6'(EVENT_PENALTY);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [3:0]            stab_q, stab_d;
  logic [3:0]            retry_q, retry_d;
  logic                  tr_q, tr_d;
  logic                  pr_q, pr_d;
  logic [NUM_PHASES-1:0] onehot;
  logic                  in_phase;
  logic                  dbg_ok;
  logic                  clr_hit;
  logic [5:0]            sum;
  logic [3:0]            stab_new;

  always_comb begin
    onehot = '0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      onehot[k] = (state_q == STATE_W'(k + 1));
    end
  end

  assign in_phase = |onehot;
  assign clr_hit  = |(phase_clear & onehot);
  assign dbg_ok   = debug_force && (debug_state != S_IDLE)
                    && (debug_state <= S_LAST);

  // Two's-complement in 6 bits; bit 5 flags a negative result.
  always_comb begin
    sum = {2'b00, stab_q} + {5'b0, recover};
    if (puzzle_fail) sum = sum - FP6;
    if (event_fail)  sum = sum - EP6;
    if (sum[5])          stab_new = 4'd0;
    else if (sum > MAX6) stab_new = MAX6[3:0];
    else                 stab_new = sum[3:0];
  end

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    retry_d = retry_q;
    tr_d    = 1'b0;
    pr_d    = 1'b0;
    if (dbg_ok) begin
      state_d = debug_state;
      if (!in_phase) begin
        stab_d  = INIT4;
        retry_d = RETRY4;
        tr_d    = 1'b1;
      end
    end else if (!in_phase) begin
      if (start_pulse) begin
        state_d = S_FIRST;
        stab_d  = INIT4;
        retry_d = RETRY4;
        tr_d    = 1'b1;
      end
    end else if (time_out) begin
      state_d = S_OVER;
    end else if (stab_new == 4'd0) begin
      if ((RETRY_MODE != 0) && (retry_q != 4'd0)) begin
        stab_d  = INIT4;
        retry_d = retry_q - 4'd1;
        pr_d    = 1'b1;
      end else begin
        stab_d  = 4'd0;
        state_d = S_OVER;
      end
    end else begin
      stab_d = stab_new;
      if (clr_hit) state_d = state_q + S_FIRST;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stab_q  <= INIT4;
      retry_q <= RETRY4;
      tr_q    <= 1'b0;
      pr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      retry_q <= retry_d;
      tr_q    <= tr_d;
      pr_q    <= pr_d;
    end
  end

  assign current_state = state_q;
  assign phase_onehot  = onehot;
  assign stability     = stab_q;
  assign retries_left  = retry_q;
  assign game_enable   = in_phase;
  assign timer_reset   = tr_q;
  assign phase_restart = pr_q;
  assign game_clear    = (state_q == S_CLEAR);
  assign game_over     = (state_q == S_OVER);

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Scoreboard bench: two DUTs (retry off/on) share stimulus;
// a game-rule model queues expected outputs, a monitor compares.
module tb_game_seq_ctrl;

  localparam int N = 4;

  typedef struct {
    int st; int oh; int stab; int ret;
    int en; int tr; int pr; int clr; int ovr;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start_i;
  logic [N-1:0] clr_i;
  logic         pf_i, ef_i, rec_i, to_i, dbg_i;
  logic [3:0]   ds_i;

  logic [3:0]   st_o [2];
  logic [N-1:0] oh_o [2];
  logic [3:0]   stab_o [2];
  logic [3:0]   ret_o [2];
  logic         en_o [2], tr_o [2], pr_o [2], gc_o [2], go_o [2];

  game_seq_ctrl #(.RETRY_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_pulse(start_i),
    .phase_clear(clr_i), .puzzle_fail(pf_i), .event_fail(ef_i),
    .recover(rec_i), .time_out(to_i), .debug_force(dbg_i),
    .debug_state(ds_i), .current_state(st_o[0]),
    .phase_onehot(oh_o[0]), .stability(stab_o[0]),
    .retries_left(ret_o[0]), .game_enable(en_o[0]),
    .timer_reset(tr_o[0]), .phase_restart(pr_o[0]),
    .game_clear(gc_o[0]), .game_over(go_o[0])
  );

  game_seq_ctrl #(.RETRY_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_pulse(start_i),
    .phase_clear(clr_i), .puzzle_fail(pf_i), .event_fail(ef_i),
    .recover(rec_i), .time_out(to_i), .debug_force(dbg_i),
    .debug_state(ds_i), .current_state(st_o[1]),
    .phase_onehot(oh_o[1]), .stability(stab_o[1]),
    .retries_left(ret_o[1]), .game_enable(en_o[1]),
    .timer_reset(tr_o[1]), .phase_restart(pr_o[1]),
    .game_clear(gc_o[1]), .game_over(go_o[1])
  );

  int checks = 0;
  int passed = 0;
  obs_t q0[$];
  obs_t q1[$];

  int m_st[2], m_stab[2], m_ret[2], m_tr[2], m_pr[2];

  task automatic chk(input int m, input string nm,
                     input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL dut%0d %s: got %0d expected %0d at %0t",
                  m, nm, got, exp, $time);
  endtask

  task automatic model_step(input int m);
    int v;
    bit ph;
    ph = (m_st[m] >= 1) && (m_st[m] <= N);
    m_tr[m] = 0;
    m_pr[m] = 0;
    if (!rst_n) begin
      m_st[m] = 0; m_stab[m] = 5; m_ret[m] = 2;
    end else if (dbg_i && ds_i >= 1 && ds_i <= N) begin
      if (!ph) begin
        m_stab[m] = 5; m_ret[m] = 2; m_tr[m] = 1;
      end
      m_st[m] = int'(ds_i);
    end else if (!ph) begin
      if (start_i) begin
        m_st[m] = 1; m_stab[m] = 5; m_ret[m] = 2; m_tr[m] = 1;
      end
    end else if (to_i) begin
      m_st[m] = N + 2;
    end else begin
      v = m_stab[m] + int'(rec_i) - int'(pf_i) - 2 * int'(ef_i);
      if (v < 0) v = 0;
      if (v > 9) v = 9;
      if (v == 0) begin
        if (m == 1 && m_ret[m] > 0) begin
          m_stab[m] = 5; m_ret[m]--; m_pr[m] = 1;
        end else begin
          m_stab[m] = 0; m_st[m] = N + 2;
        end
      end else begin
        m_stab[m] = v;
        if (clr_i[m_st[m]-1]) m_st[m]++;
      end
    end
  endtask

  function automatic obs_t expect_of(input int m);
    obs_t e;
    bit ph;
    ph = (m_st[m] >= 1) && (m_st[m] <= N);
    e.st = m_st[m];
    e.oh = ph ? (1 << (m_st[m] - 1)) : 0;
    e.stab = m_stab[m];
    e.ret = m_ret[m];
    e.en = int'(ph);
    e.tr = m_tr[m];
    e.pr = m_pr[m];
    e.clr = int'(m_st[m] == N + 1);
    e.ovr = int'(m_st[m] == N + 2);
    return e;
  endfunction

  task automatic idle_inputs();
    rst_n = 1'b1; start_i = 1'b0; clr_i = '0; pf_i = 1'b0;
    ef_i = 1'b0; rec_i = 1'b0; to_i = 1'b0; dbg_i = 1'b0; ds_i = '0;
  endtask

  // Called at a negedge with inputs already set; spans one posedge.
  task automatic tick();
    for (int m = 0; m < 2; m++) model_step(m);
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic compare(input int m, input obs_t e);
    chk(m, "state", int'(st_o[m]), e.st);
    chk(m, "onehot", int'(oh_o[m]), e.oh);
    chk(m, "stability", int'(stab_o[m]), e.stab);
    chk(m, "retries", int'(ret_o[m]), e.ret);
    chk(m, "game_enable", int'(en_o[m]), e.en);
    chk(m, "timer_reset", int'(tr_o[m]), e.tr);
    chk(m, "phase_restart", int'(pr_o[m]), e.pr);
    chk(m, "game_clear", int'(gc_o[m]), e.clr);
    chk(m, "game_over", int'(go_o[m]), e.ovr);
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        compare(0, e);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        compare(1, e);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
  endtask

  task automatic go_phase(input int p);
    do_reset();
    start_i = 1'b1; tick();
    for (int k = 1; k < p; k++) begin
      clr_i = N'(1 << (k - 1)); tick();
    end
  endtask

  initial begin : stim
    int r;
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();
    tick();
    // full clear sequence
    start_i = 1'b1; tick();
    tick();
    for (int k = 0; k < N; k++) begin
      clr_i = N'(1 << k); tick();
    end
    tick();
    // wrong-phase clear, combined fail, recover saturation
    go_phase(2);
    clr_i = 4'b0001; tick();
    pf_i = 1'b1; ef_i = 1'b1; tick();
    for (int i = 0; i < 10; i++) begin
      rec_i = 1'b1; tick();
    end
    // stability to zero / retry exhaustion in phase 3
    go_phase(3);
    for (int i = 0; i < 9; i++) begin
      ef_i = 1'b1; tick();
    end
    start_i = 1'b1; tick();
    // collisions in phase 1
    go_phase(1);
    to_i = 1'b1; clr_i = 4'b0001; tick();
    go_phase(1);
    pf_i = 1'b1; ef_i = 1'b1; tick();
    ef_i = 1'b1; tick();
    pf_i = 1'b1; clr_i = 4'b0001; tick();
    pf_i = 1'b1; ef_i = 1'b1; clr_i = 4'b0001; tick();
    tick();
    // debug jumps
    do_reset();
    dbg_i = 1'b1; ds_i = 4'd3; tick();
    dbg_i = 1'b1; ds_i = 4'd0; tick();
    dbg_i = 1'b1; ds_i = 4'd7; tick();
    go_phase(2);
    pf_i = 1'b1; tick();
    dbg_i = 1'b1; ds_i = 4'd4; to_i = 1'b1; tick();
    to_i = 1'b1; tick();
    dbg_i = 1'b1; ds_i = 4'd2; tick();
    // randomized play
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 299) != 0);
      start_i = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 5);
      if (r < 2 && m_st[0] >= 1 && m_st[0] <= N)
        clr_i = N'(1 << (m_st[0] - 1));
      else if (r < 4 && m_st[1] >= 1 && m_st[1] <= N)
        clr_i = N'(1 << (m_st[1] - 1));
      else if (r == 4)
        clr_i = N'($urandom);
      pf_i  = ($urandom_range(0, 5) == 0);
      ef_i  = ($urandom_range(0, 7) == 0);
      rec_i = ($urandom_range(0, 4) == 0);
      to_i  = ($urandom_range(0, 39) == 0);
      dbg_i = ($urandom_range(0, 29) == 0);
      ds_i  = 4'($urandom_range(0, 15));
      tick();
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q0.size() == 0 && q1.size() == 0) passed++;
    else $display("FAIL drain: pending %0d/%0d expected 0",
                  q0.size(), q1.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
